// File: rtl/alu_share_seq.sv
// Round-robin sharing of one 16-bit add/sub ALU between two requesters, with a
// registered ALU interface. Define ALU_SHARE_WIDE_EN for 32-bit two-pass chaining.
module alu_share_seq #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_op,
  input  logic [1:0]      req_cin,
  input  logic [1:0]      req_wide,
  input  logic [2*DW-1:0] req_a0,
  input  logic [2*DW-1:0] req_b0,
  input  logic [2*DW-1:0] req_a1,
  input  logic [2*DW-1:0] req_b1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [2*DW-1:0] rsp_s,
  output logic            rsp_z,
  output logic            rsp_n,
  output logic            rsp_v,
  output logic            rsp_c,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic            alu_op,
  output logic            alu_cin,
  input  logic [DW-1:0]   alu_s,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_v,
  input  logic            alu_c
);

  typedef struct packed {
    logic            op;
    logic            cin;
    logic            wide;
    logic [2*DW-1:0] a;
    logic [2*DW-1:0] b;
  } req_t;

`ifdef ALU_SHARE_WIDE_EN
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LO, DONE} state_t;
`endif

  state_t        state;
  logic          ptr;
  logic          gnt_id;
  logic          gnt_vld;
  req_t          sel;
  logic [DW-1:0] s_lo;
  logic          z_q, n_q, v_q, c_q;

  // Preferred requester wins when valid; otherwise the other one (if any) does.
  always_comb begin
    gnt_id  = req_valid[ptr] ? ptr : ~ptr;
    gnt_vld = (state == IDLE) && (|req_valid);
    req_ready = '0;
    if (gnt_vld && rst_n) req_ready[gnt_id] = 1'b1;
  end

  assign sel = gnt_id ? req_t'{req_op[1], req_cin[1], req_wide[1], req_a1, req_b1}
                      : req_t'{req_op[0], req_cin[0], req_wide[0], req_a0, req_b0};

`ifdef ALU_SHARE_WIDE_EN
  logic          wide_q;
  logic [DW-1:0] a_hi_q, b_hi_q, s_hi;
  assign rsp_s = {s_hi, s_lo};
`else
  logic unused_hi;
  assign unused_hi = ^{sel.wide, sel.a[2*DW-1:DW], sel.b[2*DW-1:DW]};
  assign rsp_s = {{DW{1'b0}}, s_lo};
`endif

  assign rsp_z = z_q;
  assign rsp_n = n_q;
  assign rsp_v = v_q;
  assign rsp_c = c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      s_lo      <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      c_q       <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 1'b0;
      alu_cin   <= 1'b0;
`ifdef ALU_SHARE_WIDE_EN
      wide_q    <= 1'b0;
      a_hi_q    <= '0;
      b_hi_q    <= '0;
      s_hi      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          rsp_id  <= gnt_id;
          ptr     <= ~ptr;
          alu_a   <= sel.a[DW-1:0];
          alu_b   <= sel.b[DW-1:0];
          alu_op  <= sel.op;
          alu_cin <= sel.cin;
`ifdef ALU_SHARE_WIDE_EN
          wide_q  <= sel.wide;
          a_hi_q  <= sel.a[2*DW-1:DW];
          b_hi_q  <= sel.b[2*DW-1:DW];
`endif
          state   <= LO;
        end
        LO: begin
          s_lo <= alu_s;
          z_q  <= alu_z;
          n_q  <= alu_n;
          v_q  <= alu_v;
          c_q  <= alu_c;
`ifdef ALU_SHARE_WIDE_EN
          if (wide_q) begin
            // Subtract reports no-borrow in C, so the high pass borrows on ~C.
            alu_a   <= a_hi_q;
            alu_b   <= b_hi_q;
            alu_cin <= alu_op ? ~alu_c : alu_c;
            state   <= HI;
          end else begin
            s_hi      <= '0;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
`else
          rsp_valid <= 1'b1;
          state     <= DONE;
`endif
        end
`ifdef ALU_SHARE_WIDE_EN
        HI: begin
          s_hi      <= alu_s;
          z_q       <= z_q & alu_z;
          n_q       <= alu_n;
          v_q       <= alu_v;
          c_q       <= alu_c;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_seq.md
# alu_share_seq

Round-robin arbiter and multi-cycle sequencer that shares the single combinational 16-bit add/subtract ALU between two requesters. It drives the ALU operand, `Op` and `Cin` inputs from registers and captures `S`, `Z`, `N`, `V` and `C` one cycle later. Optionally it chains two ALU passes with carry/borrow propagation to execute 32-bit operations. It sits between the CPU's execute-stage requesters and the ALU.

## Interface
- `DW`, 16: ALU datapath width; fixed by the ALU.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid[1:0]` in 2: request valid, one bit per requester.
- `req_ready[1:0]` out 2: request accepted this cycle; at most one bit high.
- `req_op[1:0]` in 2: per requester; 0 = add, 1 = subtract.
- `req_cin[1:0]` in 2: per requester carry-in.
- `req_wide[1:0]` in 2: per requester; 1 = 32-bit operation.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32 each: operands. Upper half is ignored for narrow operations.
- `rsp_valid` out 1: result valid; held until accepted.
- `rsp_ready` in 1: result consumed.
- `rsp_id` out 1: index of the requester being answered.
- `rsp_s` out 32: result; upper half is 0 for narrow operations.
- `rsp_z`, `rsp_n`, `rsp_v`, `rsp_c` out 1 each: result flags.
- `alu_a`, `alu_b` out 16: ALU operands, registered.
- `alu_op`, `alu_cin` out 1 each: ALU controls, registered.
- `alu_s` in 16: ALU result.
- `alu_z`, `alu_n`, `alu_v`, `alu_c` in 1 each: ALU flags.

## Operation
- ALU semantics:
  - Add: S = A + B + Cin. C = carry-out.
  - Subtract: S = A − B − Cin. C = 1 when A ≥ B + Cin (no borrow).
- States: IDLE, LO, HI, DONE.
- IDLE:
  - Round-robin grant. The pointer names the preferred requester and flips to the other one after every grant.
  - `req_ready[g]` is combinational and asserted only in IDLE for the winner `g`.
  - On the handshake: latch id, op, cin, wide and operands. Drive `alu_a`/`alu_b` = low halves, `alu_op` = op, `alu_cin` = cin. Go to LO.
- LO: capture `alu_s` into the result low half and `alu_z/n/v/c` into the flag registers.
  - Narrow: go to DONE.
  - Wide: drive the high halves. High carry-in = `alu_c` for add, ~`alu_c` for subtract. Go to HI.
- HI:
  - Capture `alu_s` into the result high half.
  - Z = z_lo & `alu_z`; N, V and C come from the high pass.
  - Go to DONE.
- DONE: `rsp_valid` = 1; all `rsp_*` outputs stable. When `rsp_valid & rsp_ready`, go to IDLE.
- Requesters hold valid and data stable until ready. A valid dropped before ready is legal and simply not granted.
- No new grant while DONE is pending (single outstanding operation).

## Timing
- Reset (asynchronous, `rst_n` low):
  - Every output is 0.
  - State = IDLE; pointer prefers requester 0.
  - An in-flight operation is discarded and produces no response.
- Latency from handshake cycle t:
  - Narrow: `rsp_valid` rises at t+2.
  - Wide: `rsp_valid` rises at t+3.
- Back-to-back throughput:
  - Narrow: one operation per 3 cycles when `rsp_ready` is held high.
  - Wide: one operation per 4 cycles under the same condition.
- Handshake in the same cycle DONE exits is not possible: the next grant occurs no earlier than the cycle after the response handshake.
- Wrap-around: 0xFFFFFFFF + 1 gives 0, C=1, Z=1.
- Single requester valid: granted regardless of the pointer, and the pointer still flips.

## Configuration
- `ALU_SHARE_WIDE_EN` defined: 32-bit chaining is enabled as described, including the HI state.
- Not defined:
  - `req_wide` is ignored and every operation is narrow.
  - The HI state and high-half registers are omitted.
  - `rsp_s[31:16]` = 0.

## Test plan
- Reset, then requester 0 narrow add 0x7FFF + 0x0001, cin 0 → `rsp_valid` at t+2; S = 0x00008000, N=1, V=1, C=0, Z=0, `rsp_id` = 0.
- Wide add 0x0000FFFF + 0x00000001, cin 0 → S = 0x00010000, C=0, Z=0; `rsp_valid` at t+3.
- Wide subtract 0x00010000 − 0x00000001, cin 0 → the low pass borrows, so the high pass has cin 1; S = 0x0000FFFF, C=1, N=0, V=0, Z=0.
- Wide add 0xFFFFFFFF + 0x00000001 → S = 0, Z=1, C=1. Without `ALU_SHARE_WIDE_EN`, the same request gives S = 0x00000000, C=1, Z=1 from the narrow pass, with upper operand bits ignored.
- Both requesters valid continuously with `rsp_ready` = 1 → grants in order 0, 1, 0, 1; `rsp_id` matches the grant order; `req_ready` is never asserted on both bits at once.
- Assert `rst_n` low during HI of a wide op → all outputs 0 immediately and no response for that op; after release, requester 0 wins the first grant.
